// File: rtl/fp_addsub_param.sv
// fp_addsub_param: multi-cycle IEEE-754 adder/subtractor with a parameterised format.
// Ports: clk, rst_n (async, active low), start, op_a, op_b, op_sub, round_mode,
//   ready_in in; result, flags {invalid,divzero,overflow,underflow,inexact},
//   valid_out, busy out.
// Build option: define FP_ADDSUB_FTZ_EN to flush subnormal inputs/results to zero.
module fp_addsub_param #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         op_sub,
   input  logic [1:0]   round_mode,
   input  logic         ready_in,
   output logic [W-1:0] result,
   output logic [4:0]   flags,
   output logic         valid_out,
   output logic         busy
);

   // hidden + fraction + guard/round/sticky
   localparam int SW = MAN_W + 4;
   localparam int EW = EXP_W + 2;

   localparam logic [EXP_W-1:0] E_ONES = '1;
   localparam logic [EXP_W-1:0] E_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
   localparam logic [EXP_W-1:0] D_FAR  = EXP_W'(MAN_W + 3);
   localparam logic [W-1:0]     QNAN   =
      {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   localparam logic [1:0] RNE = 2'd0;
   localparam logic [1:0] RTZ = 2'd1;
   localparam logic [1:0] RDN = 2'd2;
   localparam logic [1:0] RUP = 2'd3;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ALIGN = 3'd1;
   localparam logic [2:0] S_ADD   = 3'd2;
   localparam logic [2:0] S_NORM  = 3'd3;
   localparam logic [2:0] S_ROUND = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]    state;
   logic [W-1:0]  a_q, b_q;
   logic          sub_q;
   logic [1:0]    rm_q;

   // ALIGN outputs; held for the rest of the operation
   logic [EW-1:0] x_exp;
   logic [SW-1:0] x_ml, x_ms;
   logic          x_sgn, x_esub, x_spec, x_inv;
   logic [W-1:0]  x_sres;

   // ADD outputs
   logic [SW:0]   y_sum;
   logic          y_zsgn;

   // NORM outputs
   logic [SW-1:0] n_m;
   logic [EW-1:0] n_e;

   function automatic logic [EW-1:0] lzc(input logic [SW-1:0] v);
      logic done;
      lzc  = '0;
      done = 1'b0;
      for (int i = SW - 1; i >= 0; i--) begin
         if (v[i]) done = 1'b1;
         else if (!done) lzc = lzc + EW'(1);
      end
   endfunction

   // ---------------- ALIGN ----------------
   logic             sa, sb, swap;
   logic [EXP_W-1:0] ea, eb, eae, ebe, el, es, diff;
   logic [MAN_W-1:0] fa, fb;
   logic [MAN_W:0]   ma, mb, ml, ms;
   logic             nan_a, nan_b, inf_a, inf_b;
   logic             snan_a, snan_b;
   logic [SW-1:0]    ext, shd, mask, al;
   logic             spec, inv;
   logic [W-1:0]     sres;

   always_comb begin
      sa = a_q[W-1];
      sb = b_q[W-1] ^ sub_q;
      ea = a_q[W-2:MAN_W];
      eb = b_q[W-2:MAN_W];
      fa = a_q[MAN_W-1:0];
      fb = b_q[MAN_W-1:0];
      nan_a  = (ea == E_ONES) && (fa != '0);
      nan_b  = (eb == E_ONES) && (fb != '0);
      inf_a  = (ea == E_ONES) && (fa == '0);
      inf_b  = (eb == E_ONES) && (fb == '0);
      snan_a = nan_a & ~fa[MAN_W-1];
      snan_b = nan_b & ~fb[MAN_W-1];
`ifdef FP_ADDSUB_FTZ_EN
      if (ea == '0) fa = '0;
      if (eb == '0) fb = '0;
`endif
      ma  = {ea != '0, fa};
      mb  = {eb != '0, fb};
      // subnormals share the scale of exponent 1
      eae = (ea == '0) ? EXP_W'(1) : ea;
      ebe = (eb == '0) ? EXP_W'(1) : eb;
      // raw {exp,frac} order equals magnitude order
      swap = {eb, fb} > {ea, fa};
      el   = swap ? ebe : eae;
      es   = swap ? eae : ebe;
      ml   = swap ? mb : ma;
      ms   = swap ? ma : mb;
      diff = el - es;
      ext  = {ms, 3'b000};
      mask = ~({SW{1'b1}} << diff);
      shd  = ext >> diff;
      if (diff >= D_FAR) al = {{(SW-1){1'b0}}, |ms};
      else al = {shd[SW-1:1], shd[0] | (|(ext & mask))};

      spec = nan_a | nan_b | inf_a | inf_b;
      inv  = 1'b0;
      sres = QNAN;
      if (nan_a | nan_b) begin
         inv = snan_a | snan_b;
      end else if (inf_a & inf_b & (sa ^ sb)) begin
         inv = 1'b1;
      end else if (inf_a) begin
         sres = {sa, E_ONES, {MAN_W{1'b0}}};
      end else if (inf_b) begin
         sres = {sb, E_ONES, {MAN_W{1'b0}}};
      end
   end

   // ---------------- NORM ----------------
   logic [EW-1:0] lz, lim, sh, ne;
   logic [SW-1:0] nm;

   always_comb begin
      lz  = lzc(y_sum[SW-1:0]);
      // never shift the exponent below 1: gradual underflow
      lim = x_exp - EW'(1);
      sh  = (lz > lim) ? lim : lz;
      if (y_sum[SW]) begin
         nm = {y_sum[SW:2], y_sum[1] | y_sum[0]};
         ne = x_exp + EW'(1);
      end else begin
         nm = y_sum[SW-1:0] << sh;
         ne = x_exp - sh;
      end
   end

   // ---------------- ROUND ----------------
   logic             inx, up, ovf, tiny;
   logic [MAN_W+1:0] rnd;
   logic [EW-1:0]    re;
   logic [MAN_W-1:0] rf;
   logic [W-1:0]     rres, r_inf, r_max;
   logic [4:0]       rflg;

   always_comb begin
      inx = |n_m[2:0];
      up  = 1'b0;
      unique case (rm_q)
         RNE: up = n_m[2] & (n_m[1] | n_m[0] | n_m[3]);
         RTZ: up = 1'b0;
         RDN: up = x_sgn & inx;
         RUP: up = ~x_sgn & inx;
      endcase
      rnd = {1'b0, n_m[SW-1:3]} + (MAN_W+2)'(up);
      // hidden bit clear after rounding means a subnormal encoding
      if (rnd[MAN_W+1]) re = n_e + EW'(1);
      else if (rnd[MAN_W]) re = n_e;
      else re = '0;
      rf    = rnd[MAN_W-1:0];
      ovf   = re >= {2'b00, E_ONES};
      tiny  = (re == '0);
      r_inf = {x_sgn, E_ONES, {MAN_W{1'b0}}};
      r_max = {x_sgn, E_MAXF, {MAN_W{1'b1}}};
      rres  = {x_sgn, re[EXP_W-1:0], rf};
      rflg  = {3'b000, tiny & inx, inx};
      if (x_spec) begin
         rres = x_sres;
         rflg = {x_inv, 4'b0000};
      end else if (n_m == '0) begin
         rres = {y_zsgn, {(W-1){1'b0}}};
         rflg = '0;
      end else if (ovf) begin
         rflg = 5'b00101;
         rres = r_inf;
         unique case (rm_q)
            RNE: rres = r_inf;
            RTZ: rres = r_max;
            RDN: rres = x_sgn ? r_inf : r_max;
            RUP: rres = x_sgn ? r_max : r_inf;
         endcase
      end
`ifdef FP_ADDSUB_FTZ_EN
      else if (tiny) begin
         rres = {x_sgn, {(W-1){1'b0}}};
         rflg = 5'b00011;
      end
`endif
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sub_q     <= 1'b0;
         rm_q      <= RNE;
         x_exp     <= '0;
         x_ml      <= '0;
         x_ms      <= '0;
         x_sgn     <= 1'b0;
         x_esub    <= 1'b0;
         x_spec    <= 1'b0;
         x_inv     <= 1'b0;
         x_sres    <= '0;
         y_sum     <= '0;
         y_zsgn    <= 1'b0;
         n_m       <= '0;
         n_e       <= '0;
         result    <= '0;
         flags     <= '0;
         valid_out <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  a_q   <= op_a;
                  b_q   <= op_b;
                  sub_q <= op_sub;
                  rm_q  <= round_mode;
                  state <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               x_exp  <= EW'(el);
               x_ml   <= {ml, 3'b000};
               x_ms   <= al;
               x_sgn  <= swap ? sb : sa;
               x_esub <= sa ^ sb;
               x_spec <= spec;
               x_inv  <= inv;
               x_sres <= sres;
               state  <= S_ADD;
            end
            S_ADD: begin
               // larger magnitude first, so no negative difference
               y_sum  <= x_esub ? ({1'b0, x_ml} - {1'b0, x_ms})
                                : ({1'b0, x_ml} + {1'b0, x_ms});
               y_zsgn <= x_esub ? (rm_q == RDN) : x_sgn;
               state  <= S_NORM;
            end
            S_NORM: begin
               n_m   <= nm;
               n_e   <= ne;
               state <= S_ROUND;
            end
            S_ROUND: begin
               result    <= rres;
               flags     <= rflg;
               valid_out <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               if (ready_in) begin
                  valid_out <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

endmodule
